// File: rtl/eth_mac_tx_arbiter.sv
// Frame-granular round-robin arbiter feeding the 8-bit AXI-stream TX input of the RGMII MAC.
// A grant is held from the first byte to tlast, and a length guard truncates runaway frames
// by forcing tlast+tuser so the MAC aborts them.
module eth_mac_tx_arbiter #(
    parameter int unsigned S_COUNT       = 4,
    parameter int unsigned MAX_FRAME_LEN = 1518,
    parameter int unsigned LEN_WIDTH     = 12,
    parameter int unsigned SEL_WIDTH     = $clog2(S_COUNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [S_COUNT*8-1:0]   s_axis_tdata,
    input  logic [S_COUNT-1:0]     s_axis_tvalid,
    output logic [S_COUNT-1:0]     s_axis_tready,
    input  logic [S_COUNT-1:0]     s_axis_tlast,
    input  logic [S_COUNT-1:0]     s_axis_tuser,
    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser,
    input  logic                   enable,
    output logic [S_COUNT-1:0]     grant,
    output logic                   frame_truncated,
    output logic [SEL_WIDTH-1:0]   trunc_port
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [LEN_WIDTH-1:0] LP_LAST_IDX = LEN_WIDTH'(MAX_FRAME_LEN - 1);

    logic [1:0]           r_state;
    logic [S_COUNT-1:0]   r_grant;
    logic [SEL_WIDTH-1:0] r_sel;
    logic [SEL_WIDTH-1:0] r_last_grant;
    logic [LEN_WIDTH-1:0] r_count;
    logic                 r_frame_truncated;
    logic [SEL_WIDTH-1:0] r_trunc_port;

    logic [1:0]           w_state_nx;
    logic [S_COUNT-1:0]   w_grant_nx;
    logic [SEL_WIDTH-1:0] w_sel_nx;
    logic [SEL_WIDTH-1:0] w_last_grant_nx;
    logic [LEN_WIDTH-1:0] w_count_nx;
    logic                 w_frame_truncated_nx;
    logic [SEL_WIDTH-1:0] w_trunc_port_nx;

    logic [7:0]           w_sel_data;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic                 w_sel_user;
    logic                 w_force_trunc;
    logic                 w_found;
    logic [SEL_WIDTH-1:0] w_pick;

    // Selected-port view of the input streams
    always_comb begin
        w_sel_data    = s_axis_tdata[{r_sel, 3'b000} +: 8];
        w_sel_valid   = s_axis_tvalid[r_sel];
        w_sel_last    = s_axis_tlast[r_sel];
        w_sel_user    = s_axis_tuser[r_sel];
        w_force_trunc = (r_count == LP_LAST_IDX) && !w_sel_last;
    end

    // Round-robin search starting just after the previous owner
    always_comb begin
        logic [31:0] v_idx;
        w_found = 1'b0;
        w_pick  = '0;
        v_idx   = '0;
        for (int unsigned i = 1; i <= S_COUNT; i++) begin
            v_idx = (32'(r_last_grant) + 32'(i)) % 32'(S_COUNT);
            if (!w_found && s_axis_tvalid[SEL_WIDTH'(v_idx)]) begin
                w_found = 1'b1;
                w_pick  = SEL_WIDTH'(v_idx);
            end
        end
    end

    // Combinational data path: zero-latency mux in PASS, sink-only in DROP
    always_comb begin
        m_axis_tdata  = 8'h00;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        if (r_state == ST_PASS) begin
            m_axis_tdata         = w_sel_data;
            m_axis_tvalid        = w_sel_valid;
            m_axis_tlast         = w_sel_last | w_force_trunc;
            m_axis_tuser         = w_sel_user | w_force_trunc;
            s_axis_tready[r_sel] = m_axis_tready;
        end else if (r_state == ST_DROP) begin
            s_axis_tready[r_sel] = 1'b1;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        w_state_nx           = r_state;
        w_grant_nx           = r_grant;
        w_sel_nx             = r_sel;
        w_last_grant_nx      = r_last_grant;
        w_count_nx           = r_count;
        w_frame_truncated_nx = 1'b0;
        w_trunc_port_nx      = r_trunc_port;
        case (r_state)
            ST_IDLE: begin
                if (enable && w_found) begin
                    w_state_nx      = ST_PASS;
                    w_grant_nx      = S_COUNT'(1) << w_pick;
                    w_sel_nx        = w_pick;
                    w_last_grant_nx = w_pick;
                    w_count_nx      = '0;
                end
            end
            ST_PASS: begin
                if (w_sel_valid && m_axis_tready) begin
                    w_count_nx = r_count + LEN_WIDTH'(1);
                    if (w_sel_last) begin
                        w_state_nx = ST_IDLE;
                        w_grant_nx = '0;
                    end else if (w_force_trunc) begin
                        w_state_nx           = ST_DROP;
                        w_frame_truncated_nx = 1'b1;
                        w_trunc_port_nx      = r_sel;
                    end
                end
            end
            ST_DROP: begin
                if (w_sel_valid && w_sel_last) begin
                    w_state_nx = ST_IDLE;
                    w_grant_nx = '0;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_grant_nx = '0;
            end
        endcase
    end

    // State and control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= ST_IDLE;
            r_grant           <= '0;
            r_sel             <= '0;
            r_last_grant      <= SEL_WIDTH'(S_COUNT - 1);
            r_count           <= '0;
            r_frame_truncated <= 1'b0;
            r_trunc_port      <= '0;
        end else begin
            r_state           <= w_state_nx;
            r_grant           <= w_grant_nx;
            r_sel             <= w_sel_nx;
            r_last_grant      <= w_last_grant_nx;
            r_count           <= w_count_nx;
            r_frame_truncated <= w_frame_truncated_nx;
            r_trunc_port      <= w_trunc_port_nx;
        end
    end

    assign grant           = r_grant;
    assign frame_truncated = r_frame_truncated;
    assign trunc_port      = r_trunc_port;

endmodule

// File: tb/tb_eth_mac_tx_arbiter.sv
// Scoreboard bench for eth_mac_tx_arbiter: frame-level round-robin reference model,
// randomized sources/sink, directed truncation, enable and reset scenarios.
module tb_eth_mac_tx_arbiter;

    localparam int S   = 4;
    localparam int MAX = 1518;
    localparam int SW  = 2;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
    } src_t;

    typedef struct {
        int         port;
        logic [7:0] data;
        logic       last;
        logic       user;
        logic       trunc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [S*8-1:0]  s_axis_tdata;
    logic [S-1:0]    s_axis_tvalid;
    logic [S-1:0]    s_axis_tready;
    logic [S-1:0]    s_axis_tlast;
    logic [S-1:0]    s_axis_tuser;
    logic [7:0]      m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic            m_axis_tuser;
    logic            enable;
    logic [S-1:0]    grant;
    logic            frame_truncated;
    logic [SW-1:0]   trunc_port;

    eth_mac_tx_arbiter #(.S_COUNT(S), .MAX_FRAME_LEN(MAX), .LEN_WIDTH(12)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .enable(enable), .grant(grant), .frame_truncated(frame_truncated), .trunc_port(trunc_port)
    );

    always #5 clk = ~clk;

    src_t src_q [S][$];
    src_t mdl_q [S][$];
    exp_t exp_q [$];
    int   trunc_q [$];
    int   mdl_last = S - 1;
    bit   first [S] = '{default: 1'b1};
    bit   gaps    = 1'b0;
    int   rdy_mode = 0;
    bit   sb_en   = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [S-1:0] onehot(input int p);
        logic [S-1:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    // Frame of len bytes; tlast on the final byte when has_last; tuser on final byte when user
    task automatic load_frame(input int p, input int len, input bit has_last, input bit user);
        src_t b;
        for (int k = 1; k <= len; k++) begin
            b.data = 8'($urandom);
            b.last = has_last && (k == len);
            b.user = user && (k == len);
            src_q[p].push_back(b);
            mdl_q[p].push_back(b);
        end
    endtask

    // Reference: serve whole frames round-robin over ports holding frames; cap at MAX bytes
    task automatic model_run();
        bit   any;
        int   c;
        int   k;
        src_t b;
        exp_t e;
        forever begin
            any = 1'b0;
            c = 0;
            for (int i = 1; i <= S; i++) begin
                if (!any && mdl_q[(mdl_last + i) % S].size() > 0) begin
                    any = 1'b1;
                    c = (mdl_last + i) % S;
                end
            end
            if (!any) break;
            mdl_last = c;
            k = 0;
            do begin
                b = mdl_q[c].pop_front();
                k++;
                e.port = c; e.data = b.data; e.last = b.last; e.user = b.user; e.trunc = 1'b0;
                if (k < MAX || (k == MAX && b.last)) begin
                    exp_q.push_back(e);
                end else if (k == MAX) begin
                    e.last = 1'b1; e.user = 1'b1; e.trunc = 1'b1;
                    exp_q.push_back(e);
                    trunc_q.push_back(c);
                end
            end while (!b.last && mdl_q[c].size() > 0);
        end
    endtask

    function automatic bit src_empty();
        for (int p = 0; p < S; p++) if (src_q[p].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (!(src_empty() && exp_q.size() == 0 && trunc_q.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain_timeout"}, 64'(n >= budget), 64'(0));
        repeat (3) @(negedge clk);
    endtask

    // Source and sink drivers: handshakes observed at negedge, new values applied after posedge
    initial begin
        bit             hs [S];
        logic [S*8-1:0] d;
        logic [S-1:0]   v, l, u;
        s_axis_tdata = '0; s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tuser = '0;
        m_axis_tready = 1'b1;
        forever begin
            @(negedge clk);
            for (int p = 0; p < S; p++) hs[p] = s_axis_tvalid[p] && s_axis_tready[p];
            @(posedge clk);
            #1;
            d = '0; v = '0; l = '0; u = '0;
            for (int p = 0; p < S; p++) begin
                if (hs[p] && src_q[p].size() > 0) first[p] = src_q[p].pop_front().last;
                if (src_q[p].size() > 0) begin
                    d[p*8 +: 8] = src_q[p][0].data;
                    l[p] = src_q[p][0].last;
                    u[p] = src_q[p][0].user;
                    v[p] = first[p] || !gaps || ($urandom_range(0, 3) != 0);
                end
            end
            s_axis_tdata = d; s_axis_tvalid = v; s_axis_tlast = l; s_axis_tuser = u;
            case (rdy_mode)
                1:       m_axis_tready = ($urandom_range(0, 3) != 0);
                2:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'b1;
            endcase
        end
    end

    // Monitor: pops expectations whenever the DUT presents a byte or a truncation pulse
    initial begin
        bit   prev_end;
        exp_t e;
        int   tp;
        prev_end = 1'b0;
        forever begin
            @(negedge clk);
            if (sb_en && !rst) begin
                if (prev_end) chk("bubble_after_frame", 64'({grant, m_axis_tvalid}), 64'(0));
                prev_end = 1'b0;
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_byte: got data %0h grant %0b, expected none", m_axis_tdata, grant);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_byte", 64'({grant, m_axis_tdata, m_axis_tlast, m_axis_tuser}),
                            64'({onehot(e.port), e.data, e.last, e.user}));
                        prev_end = e.last && !e.trunc;
                    end
                end
                if (frame_truncated) begin
                    if (trunc_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_trunc: got trunc_port %0d, expected no pulse", trunc_port);
                    end else begin
                        tp = trunc_q.pop_front();
                        chk("trunc_port", 64'(trunc_port), 64'(tp));
                    end
                end
            end else begin
                prev_end = 1'b0;
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("rst_s_tready", 64'(s_axis_tready), 64'(0));
        chk("rst_trunc", 64'({frame_truncated, trunc_port}), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // All four ports, three 64-byte frames each
        for (int f = 0; f < 3; f++) for (int p = 0; p < S; p++) load_frame(p, 64, 1'b1, 1'b0);
        model_run();
        wait_drain("rr_all", 5000);

        // Single port, toggling sink ready
        rdy_mode = 2;
        load_frame(2, 100, 1'b1, 1'b0);
        model_run();
        wait_drain("toggle_ready", 1000);

        // Randomized rounds: gaps, random ready, random tuser
        gaps = 1'b1; rdy_mode = 1;
        for (int r = 0; r < 6; r++) begin
            for (int p = 0; p < S; p++) begin
                n = $urandom_range(0, 3);
                for (int f = 0; f < n; f++)
                    load_frame(p, $urandom_range(1, 40), 1'b1, ($urandom_range(0, 7) == 0));
            end
            model_run();
            wait_drain("random", 5000);
        end
        gaps = 1'b0; rdy_mode = 0;

        // Runaway frame on port 1 plus a short frame on port 2
        load_frame(1, 2000, 1'b1, 1'b0);
        load_frame(2, 10, 1'b1, 1'b0);
        model_run();
        wait_drain("truncate", 8000);

        // Exactly MAX bytes with tlast: not truncated
        load_frame(3, MAX, 1'b1, 1'b0);
        model_run();
        wait_drain("exact_max", 4000);

        // enable dropped mid-frame on port 0 while port 3 waits
        load_frame(0, 50, 1'b1, 1'b0);
        model_run();
        n = 0;
        while (!grant[0] && n < 100) begin @(negedge clk); n++; end
        chk("en_grant0", 64'(grant), 64'(onehot(0)));
        enable = 1'b0;
        load_frame(3, 5, 1'b1, 1'b0);
        model_run();
        n = 0;
        while (src_q[0].size() != 0 && n < 500) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        chk("en_hold", 64'({grant, m_axis_tvalid}), 64'(0));
        @(posedge clk); #2;
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("en_resume_grant3", 64'(grant), 64'(onehot(3)));
        wait_drain("enable", 500);

        // Asynchronous reset mid-frame on port 2
        sb_en = 1'b0;
        load_frame(2, 100, 1'b1, 1'b0);
        n = 0;
        while (!grant[2] && n < 100) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_grant", 64'(grant), 64'(0));
        chk("async_rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        for (int p = 0; p < S; p++) begin
            src_q[p].delete(); mdl_q[p].delete(); first[p] = 1'b1;
        end
        exp_q.delete(); trunc_q.delete();
        mdl_last = S - 1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sb_en = 1'b1;
        repeat (3) @(negedge clk);
        load_frame(2, 8, 1'b1, 1'b0);
        load_frame(0, 8, 1'b1, 1'b0);
        model_run();
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_port0_first", 64'(grant), 64'(onehot(0)));
        wait_drain("post_rst", 500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
